sample_expand: RTL and testbench
================================

# sample_expand

Upsampling counterpart to the decimation stage on the capture path. Accepts audio samples at the low rate through a valid/ready handshake. Emits EXPAND_FACTOR output samples per input sample, each in response to a request strobe from the I2S transmitter. Output is either linearly interpolated between consecutive inputs or zero-order held. The block sits between the sample source (FIFO/DSP) and the I2S transmitter on the playback path.

## Interface
- DATA_SIZE, 24, sample width; two's-complement signed.
- EXPAND_FACTOR, 4, outputs per input; power of two, 1..256; elaboration error otherwise.
- INTERP, 1, 1 = linear interpolation, 0 = zero-order hold.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- audio_data_in  in  DATA_SIZE  input sample.
- req_i2s  in  1  one-cycle strobe: transmitter wants the next output sample.
- done  out  1  one-cycle pulse: audio_data_out updated.
- audio_data_out  out  DATA_SIZE  output sample.
- underrun  out  1  one-cycle pulse: request served with no new input available.

## Operation
- State registers:
  - prev, cur: segment endpoints.
  - nxt: pending input; nxt_valid flags it.
  - phase: 0..EXPAND_FACTOR-1, width log2(EXPAND_FACTOR), minimum 1 bit.
- Input handshake:
  - in_ready = !nxt_valid, combinational from the register only.
  - Transfer when in_valid && in_ready: nxt <= audio_data_in, nxt_valid <= 1.
- Request at phase 0 with nxt_valid = 1 (segment start):
  - prev <= cur, cur <= nxt, nxt_valid <= 0.
  - Output k = 0; phase <= 1, or stays 0 when EXPAND_FACTOR = 1.
- Request at phase 0 with nxt_valid = 0 (underrun):
  - Output = cur; prev <= cur; phase stays 0; underrun pulses.
  - Next request retries the segment start.
- Request at phase k > 0:
  - Output for k; phase <= k+1, wrapping to 0 after EXPAND_FACTOR-1.
- Output value, using prev/cur after any update in the same cycle:
  - INTERP = 1: out = prev + (((cur - prev) * k) >>> L), where L = log2(EXPAND_FACTOR).
  - INTERP = 0: out = prev.
- Arithmetic:
  - Difference is DATA_SIZE+1 bits signed.
  - Product is DATA_SIZE+1+L bits signed.
  - Shift is arithmetic, which floors toward negative infinity.
  - Result always lies between prev and cur, so truncating to DATA_SIZE is lossless.
- Simultaneous in_valid and a segment-start request: in_ready is already 0 (nxt is occupied), so there is no bypass. The new sample transfers on a later cycle.
- Simultaneous in_valid and an underrun request: the transfer happens and the request still underruns; there is no same-cycle forwarding.

## Timing
- Reset values: prev, cur, nxt, audio_data_out = 0; nxt_valid = 0; phase = 0; done = 0; underrun = 0; in_ready = 1 in the first cycle after reset release.
- done and underrun are registered. They assert the cycle after req_i2s and last exactly one cycle.
- audio_data_out changes only with done and holds between pulses.
- req_i2s may assert every cycle; each strobe yields exactly one done.
- in_ready returns to 1 the cycle after a segment start consumes nxt.
- Assertion of rst_n mid-operation clears all state immediately, including a pending nxt and any in-flight done.
- Input-to-output latency: a sample first appears as cur. It reaches the output as prev, at k = 0, one segment after acceptance.

## Structure
- Shared package audio_pkg holds:
  - the EXPAND_FACTOR power-of-two check function;
  - a clog2-with-minimum-1 helper, shared with the decimator.
- Width-dependent types stay local to the block.
- One sub-module, sample_interp_calc: combinational (prev, cur, k) -> out, with INTERP and widths as parameters. It is unit-testable alone.
- The top module holds the handshake, phase counter and registers.

## Test plan
- Reset: hold rst_n low with req_i2s toggling -> done = 0, audio_data_out = 0, in_ready = 1.
- Ramp (DATA_SIZE 24, EXPAND_FACTOR 4, INTERP 1): push 400, issue 4 reqs -> outputs 0, 100, 200, 300. Push 0, 4 reqs -> 400, 300, 200, 100.
- Signed floor: prev = -4, cur = 1 -> outputs -4, -3, -2, -1. With INTERP 0, the same stimulus gives -4 four times.
- Underrun: after cur = 400, req at phase 0 with nothing pushed -> done with 400, underrun pulse, phase stays 0. Then push 800 and issue 4 reqs -> 400, 500, 600, 700.
- Backpressure: push two samples with no reqs -> second in_valid is stalled (in_ready = 0). After one phase-0 req, in_ready = 1 the next cycle and the stalled sample transfers.
- Reset mid-operation: assert rst_n at phase 2 with nxt pending -> all outputs 0 at once, nxt is discarded, and the next req underruns with output 0.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared helpers for the audio rate-conversion blocks
//               (expander and decimator).
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // True when the expansion factor is a power of two in 1..256.
    function automatic bit is_valid_expand(input int v);
        return (v >= 1) && (v <= 256) && ((v & (v - 1)) == 0);
    endfunction

    // Ceiling log2, never less than 1 so counters always have a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_interp_calc.sv
`default_nettype none
// ============================================================================
// Module      : sample_interp_calc
// Description : Combinational segment point: prev + floor((cur-prev)*k / 2^SHIFT)
//               for linear interpolation, or prev for zero-order hold.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_interp_calc #(
    parameter int DATA_SIZE = 24,
    parameter int SHIFT     = 2,
    parameter int K_W       = 2,
    parameter bit INTERP    = 1'b1
) (
    input  logic signed [DATA_SIZE-1:0] i_prev,
    input  logic signed [DATA_SIZE-1:0] i_cur,
    input  logic        [K_W-1:0]       i_k,
    output logic        [DATA_SIZE-1:0] o_out
);
    localparam int PROD_W = DATA_SIZE + 1 + SHIFT;

    logic signed [DATA_SIZE:0]  w_diff;
    logic signed [PROD_W-1:0]   w_diff_ext;
    logic signed [PROD_W-1:0]   w_k_ext;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [PROD_W-1:0]   w_shift;
    logic                       w_unused_hi;

    // One extra bit keeps the difference exact; the arithmetic shift floors
    // toward negative infinity, so the result stays within [prev, cur] and the
    // upper bits can be dropped.
    always_comb begin
        w_diff      = $signed({i_cur[DATA_SIZE-1], i_cur}) - $signed({i_prev[DATA_SIZE-1], i_prev});
        w_diff_ext  = PROD_W'(w_diff);
        w_k_ext     = PROD_W'(i_k);
        w_prod      = w_diff_ext * w_k_ext;
        w_shift     = w_prod >>> SHIFT;
        w_unused_hi = ^w_shift[PROD_W-1:DATA_SIZE];
        if (INTERP) begin
            o_out = i_prev + w_shift[DATA_SIZE-1:0];
        end else begin
            o_out = i_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_expand.sv
`default_nettype none
// ============================================================================
// Module      : sample_expand
// Description : Playback-path upsampler. Takes low-rate samples via
//               valid/ready and emits EXPAND_FACTOR samples per input, one per
//               I2S request, interpolated or zero-order held.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_expand
    import audio_pkg::*;
#(
    parameter int DATA_SIZE     = 24,
    parameter int EXPAND_FACTOR = 4,
    parameter bit INTERP        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] audio_data_in,
    input  logic                 req_i2s,
    output logic                 done,
    output logic [DATA_SIZE-1:0] audio_data_out,
    output logic                 underrun
);
    localparam int             L      = $clog2(EXPAND_FACTOR);
    localparam int             PW     = clog2_min1(EXPAND_FACTOR);
    localparam logic [PW-1:0]  c_LAST = PW'(EXPAND_FACTOR - 1);

    generate
        if (!is_valid_expand(EXPAND_FACTOR)) begin : g_bad_factor
            $error("sample_expand: EXPAND_FACTOR must be a power of two in 1..256");
        end
    endgenerate

    logic [DATA_SIZE-1:0] r_prev, r_cur, r_nxt, r_out;
    logic                 r_nxt_valid, r_done, r_underrun;
    logic [PW-1:0]        r_phase;

    logic                 w_req_start, w_seg_start, w_underrun;
    logic [DATA_SIZE-1:0] w_prev_upd, w_cur_upd, w_calc;
    logic [PW-1:0]        w_phase_next;

    // Segment-boundary decode and the prev/cur values the output is computed from.
    always_comb begin
        w_req_start  = req_i2s && (r_phase == '0);
        w_seg_start  = w_req_start && r_nxt_valid;
        w_underrun   = w_req_start && !r_nxt_valid;
        w_prev_upd   = w_req_start ? r_cur : r_prev;
        w_cur_upd    = w_seg_start ? r_nxt : r_cur;
        w_phase_next = (r_phase == c_LAST) ? '0 : r_phase + PW'(1);
    end

    sample_interp_calc #(
        .DATA_SIZE (DATA_SIZE),
        .SHIFT     (L),
        .K_W       (PW),
        .INTERP    (INTERP)
    ) u_calc (
        .i_prev (w_prev_upd),
        .i_cur  (w_cur_upd),
        .i_k    (r_phase),
        .o_out  (w_calc)
    );

    // Handshake, segment registers, phase counter and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_cur       <= '0;
            r_nxt       <= '0;
            r_out       <= '0;
            r_nxt_valid <= 1'b0;
            r_phase     <= '0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done     <= req_i2s;
            r_underrun <= w_underrun;
            if (req_i2s) begin
                r_out  <= w_calc;
                r_prev <= w_prev_upd;
                r_cur  <= w_cur_upd;
                // An underrun leaves the phase at 0 so the next request retries.
                if (!w_underrun) r_phase <= w_phase_next;
            end
            // nxt is never consumed and refilled in the same cycle: ready is low while it is full.
            if (w_seg_start) begin
                r_nxt_valid <= 1'b0;
            end else if (in_valid && !r_nxt_valid) begin
                r_nxt       <= audio_data_in;
                r_nxt_valid <= 1'b1;
            end
        end
    end

    assign in_ready       = !r_nxt_valid;
    assign done           = r_done;
    assign underrun       = r_underrun;
    assign audio_data_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_sample_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_expand
// Description : Self-checking bench for sample_expand (24 bit, x4), with an
//               interpolating and a zero-order-hold instance on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_expand;
    localparam int DS = 24;
    localparam int EF = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DS-1:0] audio_data_in = '0;
    logic          req_i2s = 1'b0;
    logic          in_ready_i, done_i, underrun_i;
    logic [DS-1:0] out_i;
    logic          in_ready_z, done_z, underrun_z;
    logic [DS-1:0] out_z;

    int checks = 0;
    int failures = 0;

    // Reference model state, as plain integers
    int m_prev, m_cur, m_nxt, m_phase;
    bit m_nxt_valid;

    always #5 clk = ~clk;

    sample_expand #(.DATA_SIZE(DS), .EXPAND_FACTOR(EF), .INTERP(1'b1)) u_dut_i (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_i),
        .audio_data_in(audio_data_in), .req_i2s(req_i2s), .done(done_i),
        .audio_data_out(out_i), .underrun(underrun_i)
    );

    sample_expand #(.DATA_SIZE(DS), .EXPAND_FACTOR(EF), .INTERP(1'b0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .audio_data_in(audio_data_in), .req_i2s(req_i2s), .done(done_z),
        .audio_data_out(out_z), .underrun(underrun_z)
    );

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    // One request; checks both instances one cycle later.
    task automatic do_req(input string name, input int exp_i, input int exp_z, input bit exp_u);
        logic [DS-1:0] ei, ez;
        ei = DS'(exp_i);
        ez = DS'(exp_z);
        @(negedge clk);
        req_i2s = 1'b1;
        @(negedge clk);
        req_i2s = 1'b0;
        checks++;
        if (done_i !== 1'b1 || out_i !== ei || underrun_i !== exp_u) begin
            failures++;
            $display("FAIL %s interp: done=%b out=%0d under=%b, required done=1 out=%0d under=%b",
                     name, done_i, $signed(out_i), underrun_i, $signed(ei), exp_u);
        end
        checks++;
        if (done_z !== 1'b1 || out_z !== ez) begin
            failures++;
            $display("FAIL %s zoh: done=%b out=%0d, required done=1 out=%0d",
                     name, done_z, $signed(out_z), $signed(ez));
        end
    endtask

    task automatic push(input string name, input int val);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        audio_data_in = DS'(val);
        while (!in_ready_i && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $display("FAIL %s push timeout: in_ready=%b, required 1", name, in_ready_i);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_i2s = i[0];
        end
        req_i2s = 1'b0;
        checks++;
        if (done_i !== 1'b0 || out_i !== '0 || in_ready_i !== 1'b1 || underrun_i !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: done=%b out=%0d ready=%b under=%b, required 0 0 1 0",
                     done_i, out_i, in_ready_i, underrun_i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_i !== 1'b1 || done_i !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b done=%b, required 1 0", in_ready_i, done_i);
        end
    endtask

    task automatic test_ramp();
        push("ramp", 400);
        do_req("ramp_up0", 0, 0, 0);
        do_req("ramp_up1", 100, 0, 0);
        do_req("ramp_up2", 200, 0, 0);
        do_req("ramp_up3", 300, 0, 0);
        push("ramp", 0);
        do_req("ramp_dn0", 400, 400, 0);
        do_req("ramp_dn1", 300, 400, 0);
        do_req("ramp_dn2", 200, 400, 0);
        do_req("ramp_dn3", 100, 400, 0);
    endtask

    task automatic test_signed_floor();
        push("floor", -4);
        for (int k = 0; k < 4; k++) do_req("floor_0_to_m4", -k, 0, 0);
        push("floor", 1);
        do_req("floor_up0", -4, -4, 0);
        do_req("floor_up1", -3, -4, 0);
        do_req("floor_up2", -2, -4, 0);
        do_req("floor_up3", -1, -4, 0);
        push("floor", -4);
        do_req("floor_dn0", 1, 1, 0);
        do_req("floor_dn1", -1, 1, 0);
        do_req("floor_dn2", -2, 1, 0);
        do_req("floor_dn3", -3, 1, 0);
    endtask

    task automatic test_underrun();
        push("under", 400);
        do_req("under_seg0", -4, -4, 0);
        do_req("under_seg1", 97, -4, 0);
        do_req("under_seg2", 198, -4, 0);
        do_req("under_seg3", 299, -4, 0);
        do_req("under_empty", 400, 400, 1);
        push("under", 800);
        do_req("under_retry0", 400, 400, 0);
        do_req("under_retry1", 500, 400, 0);
        do_req("under_retry2", 600, 400, 0);
        do_req("under_retry3", 700, 400, 0);
    endtask

    task automatic test_backpressure();
        push("bp", 1000);
        @(negedge clk);
        in_valid = 1'b1;
        audio_data_in = DS'(2000);
        checks++;
        if (in_ready_i !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: in_ready=%b, required 0", in_ready_i);
        end
        @(negedge clk);
        checks++;
        if (in_ready_i !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall_hold: in_ready=%b, required 0", in_ready_i);
        end
        req_i2s = 1'b1;
        @(negedge clk);
        req_i2s = 1'b0;
        checks++;
        if (in_ready_i !== 1'b1 || done_i !== 1'b1 || out_i !== DS'(800)) begin
            failures++;
            $display("FAIL bp_release: ready=%b done=%b out=%0d, required 1 1 800",
                     in_ready_i, done_i, out_i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready_i !== 1'b0) begin
            failures++;
            $display("FAIL bp_transfer: in_ready=%b, required 0", in_ready_i);
        end
        do_req("bp_seg1", 850, 800, 0);
        do_req("bp_seg2", 900, 800, 0);
        do_req("bp_seg3", 950, 800, 0);
        do_req("bp_next0", 1000, 1000, 0);
        checks++;
        if (in_ready_i !== 1'b1) begin
            failures++;
            $display("FAIL bp_consumed: in_ready=%b, required 1", in_ready_i);
        end
    endtask

    task automatic test_reset_mid();
        do_req("mid_seg1", 1250, 1000, 0);
        push("mid", 3000);
        @(negedge clk);
        req_i2s = 1'b1;
        @(posedge clk);
        #1;
        req_i2s = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (done_i !== 1'b0 || out_i !== '0 || in_ready_i !== 1'b1 || out_z !== '0) begin
            failures++;
            $display("FAIL mid_reset: done=%b out=%0d ready=%b outz=%0d, required 0 0 1 0",
                     done_i, out_i, in_ready_i, out_z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req("mid_after", 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        push("b2b", 400);
        @(negedge clk);
        req_i2s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) req_i2s = 1'b0;
            checks++;
            if (done_i !== 1'b1 || out_i !== DS'(100 * k)) begin
                failures++;
                $display("FAIL b2b_%0d: done=%b out=%0d, required 1 %0d", k, done_i, out_i, 100 * k);
            end
        end
        @(negedge clk);
        checks++;
        if (done_i !== 1'b0 || out_i !== DS'(300)) begin
            failures++;
            $display("FAIL b2b_hold: done=%b out=%0d, required 0 300", done_i, out_i);
        end
    endtask

    task automatic test_random();
        int r, v, ei, ez;
        bit eu;
        apply_reset();
        m_prev = 0; m_cur = 0; m_nxt = 0; m_phase = 0; m_nxt_valid = 0;
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0 && !m_nxt_valid) begin
                v = int'($signed(DS'($urandom)));
                push("rand_push", v);
                m_nxt = v;
                m_nxt_valid = 1;
            end else begin
                eu = 0;
                if (m_phase == 0) begin
                    if (m_nxt_valid) begin
                        m_prev = m_cur;
                        m_cur = m_nxt;
                        m_nxt_valid = 0;
                        m_phase = 1 % EF;
                    end else begin
                        m_prev = m_cur;
                        eu = 1;
                    end
                    ei = m_prev;
                end else begin
                    ei = m_prev + floor_div((m_cur - m_prev) * m_phase, EF);
                    m_phase = (m_phase + 1) % EF;
                end
                ez = m_prev;
                do_req("rand_req", ei, ez, eu);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_signed_floor();
        test_underrun();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
